// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its stream-side read master.
package fifo_pkg;
  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry ordered buffer; head is the oldest word. Push and pop in the same
// cycle are both applied, so the occupancy stays constant.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [SKID_CNT_W-1:0] o_count,
  output logic [WIDTH-1:0]      o_head
);

  logic [SKID_CNT_W-1:0] r_count;
  logic [WIDTH-1:0]      r_mem0;
  logic [WIDTH-1:0]      r_mem1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_mem0  <= '0;
      r_mem1  <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == '0) r_mem0 <= i_data;
          else               r_mem1 <= i_data;
          r_count <= r_count + 1'b1;
        end
        2'b01: begin
          r_mem0  <= r_mem1;
          r_count <= r_count - 1'b1;
        end
        2'b11: begin
          // Full buffer: shift the second entry forward and append behind it.
          if (r_count == SKID_CNT_W'(SKID_DEPTH)) begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_data;
          end else begin
            r_mem0 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem0;

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-side master: converts the FIFO's registered read port into a
// bubble-free valid/ready stream framed into fixed-length bursts.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fifo_rd_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             idle
);

  localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

  logic                  r_inflight;
  logic [15:0]           r_beat_cnt;
  logic [SKID_CNT_W-1:0] w_count;
  logic                  w_pop;
  logic [2:0]            w_need;

  skid_buf2 #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (fifo_rdata),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_head  (m_data)
  );

  assign m_valid = (w_count != '0);
  assign w_pop   = m_valid & m_ready;

  // Credit check: words held plus the one in flight, less the one leaving now,
  // must leave room for the word requested this cycle.
  assign w_need     = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
  assign fifo_rd_en = !rst & !fifo_empty & (w_need <= 3'd1);

  assign m_last = m_valid & (r_beat_cnt == LAST_BEAT);
  assign idle   = fifo_empty & (w_count == '0) & !r_inflight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      if (w_pop) begin
        if (r_beat_cnt == LAST_BEAT) r_beat_cnt <= '0;
        else                         r_beat_cnt <= r_beat_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO on its read port.
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_rd_en, m_valid, m_last, idle;
  logic       fifo_empty = 1'b1;
  logic       m_ready = 1'b0;
  fifo_word_t fifo_rdata = '0;
  fifo_word_t m_data;

  logic       fifo_rd_en2, m_valid2, m_last2, idle2;
  logic       fifo_empty2 = 1'b1;
  logic       m_ready2 = 1'b1;
  fifo_word_t fifo_rdata2 = '0;
  fifo_word_t m_data2;

  fifo_word_t q[$], pre[$], q2[$], pre2[$], exp_q[$];
  int n_chk = 0, n_pass = 0;
  int occ = 0, occ_max = 0;

  typedef struct {
    logic       rdy;
    logic       rd;
    logic       vld;
    logic [15:0] data;
    logic       last;
    logic       idl;
  } vec_t;
  vec_t v1[11];

  fifo_stream_reader #(.WIDTH(16), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .idle(idle)
  );

  fifo_stream_reader #(.WIDTH(16), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en2), .fifo_empty(fifo_empty2),
    .fifo_rdata(fifo_rdata2), .m_valid(m_valid2), .m_ready(m_ready2),
    .m_data(m_data2), .m_last(m_last2), .idle(idle2)
  );

  always #5 clk = ~clk;

  // Behavioural FIFOs: registered read data, writes land at the edge.
  always @(posedge clk) begin
    if (fifo_rd_en && q.size() > 0) fifo_rdata <= q.pop_front();
    while (pre.size() > 0) q.push_back(pre.pop_front());
    fifo_empty <= (q.size() == 0);
  end

  always @(posedge clk) begin
    if (fifo_rd_en2 && q2.size() > 0) fifo_rdata2 <= q2.pop_front();
    while (pre2.size() > 0) q2.push_back(pre2.pop_front());
    fifo_empty2 <= (q2.size() == 0);
  end

  // Independent occupancy model: granted reads minus accepted beats.
  always @(posedge clk or posedge rst) begin
    int nxt;
    if (rst) begin
      occ <= 0;
    end else begin
      nxt = occ + int'(fifo_rd_en) - int'(m_valid && m_ready);
      occ <= nxt;
      if (nxt > occ_max) occ_max <= nxt;
      assert (nxt <= 2) else $display("FAIL occupancy actual=%0d required<=2", nxt);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int rdc, vcnt, got, np, nr;

    v1[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    v1[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    v1[2]  = '{1'b1, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b0};
    v1[3]  = '{1'b1, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b0};
    v1[4]  = '{1'b1, 1'b1, 1'b1, 16'h3333, 1'b0, 1'b0};
    v1[5]  = '{1'b1, 1'b1, 1'b1, 16'h4444, 1'b1, 1'b0};
    v1[6]  = '{1'b1, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0};
    v1[7]  = '{1'b1, 1'b1, 1'b1, 16'h6666, 1'b0, 1'b0};
    v1[8]  = '{1'b1, 1'b0, 1'b1, 16'h7777, 1'b0, 1'b0};
    v1[9]  = '{1'b1, 1'b0, 1'b1, 16'h8888, 1'b1, 1'b0};
    v1[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};

    #1;
    check("reset_state", 64'({fifo_rd_en, m_valid, m_last, idle, m_data}),
          64'({1'b0, 1'b0, 1'b0, 1'b1, 16'h0000}));
    @(negedge clk);
    rst = 1'b0;

    // Test 1: preloaded FIFO, continuous ready
    @(negedge clk);
    m_ready = 1'b1;
    for (int k = 1; k <= FIFO_DEPTH; k++) pre.push_back(16'(k * 'h1111));
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      m_ready = v1[i].rdy;
      #1;
      check($sformatf("t1_vec%0d", i),
            64'({fifo_rd_en, m_valid, m_last, idle, (m_valid ? m_data : 16'h0000)}),
            64'({v1[i].rd, v1[i].vld, v1[i].last, v1[i].idl, (v1[i].vld ? v1[i].data : 16'h0000)}));
    end

    // Test 2: consumer stall with 6 words queued, then release
    @(negedge clk);
    m_ready = 1'b0;
    for (int k = 0; k < 6; k++) pre.push_back(16'h2001 + 16'(k));
    rdc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      rdc += int'(fifo_rd_en);
      if (c >= 2) check("t2_hold", 64'({m_valid, m_data}), 64'({1'b1, 16'h2001}));
    end
    check("t2_rd_pulses", 64'(rdc), 64'(2));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      check("t2_drain", 64'({m_valid, m_last, m_data}),
            64'({1'b1, (i == 3), 16'h2001 + 16'(i)}));
    end

    // Test 3: toggling ready with a concurrent writer
    np = 0;
    nr = 0;
    for (int cyc = 0; cyc < 200 && nr < 12; cyc++) begin
      @(negedge clk);
      m_ready = (cyc % 2 == 0);
      if (np < 12) begin
        pre.push_back(16'hA000 + 16'(np));
        exp_q.push_back(16'hA000 + 16'(np));
        np++;
      end
      #1;
      if (m_valid && m_ready) begin
        if (exp_q.size() > 0) check("t3_order", 64'(m_data), 64'(exp_q.pop_front()));
        else check("t3_extra", 64'(m_data), 64'hFFFF_FFFF);
        nr++;
      end
    end
    check("t3_count", 64'(nr), 64'(12));
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("t3_drained", 64'({m_valid, idle}), 64'({1'b0, 1'b1}));
    check("t3_occ_max_le2", 64'(occ_max <= 2), 64'(1));

    // Test 4: single word into an empty FIFO
    rst_pulse();
    @(negedge clk);
    m_ready = 1'b1;
    pre.push_back(16'hBEEF);
    rdc = 0;
    vcnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      rdc += int'(fifo_rd_en);
      if (m_valid) begin
        vcnt++;
        check("t4_word", 64'({m_last, m_data}), 64'({1'b0, 16'hBEEF}));
      end
    end
    check("t4_rd_pulses", 64'(rdc), 64'(1));
    check("t4_valid_seen", 64'(vcnt), 64'(1));
    check("t4_idle", 64'(idle), 64'(1));

    // Test 5: asynchronous reset mid-burst
    rst_pulse();
    @(negedge clk);
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) pre.push_back(16'h5001 + 16'(k));
    for (int c = 0; c < 6; c++) @(negedge clk);
    #1;
    check("t5_before_rst", 64'({fifo_rd_en, m_valid, m_last, m_data}),
          64'({1'b1, 1'b1, 1'b1, 16'h5004}));
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_rst", 64'({fifo_rd_en, m_valid, m_last, m_data}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    pre.push_back(16'h5009);
    pre.push_back(16'h500A);
    got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      @(negedge clk);
      #1;
      if (m_valid && m_ready) begin
        check("t5_word", 64'({m_last, m_data}), 64'({(got == 3), 16'h5006 + 16'(got)}));
        got++;
      end
    end
    check("t5_got", 64'(got), 64'(4));

    // Test 6: BURST_LEN=1 instance
    @(negedge clk);
    for (int k = 0; k < 3; k++) pre2.push_back(16'h6001 + 16'(k));
    got = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #1;
      if (m_valid2 && m_ready2) begin
        check("t6_beat", 64'({m_last2, m_data2}), 64'({1'b1, 16'h6001 + 16'(got)}));
        got++;
      end
    end
    check("t6_got", 64'(got), 64'(3));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
